// File: rtl/dvbs2_tx_pkg.sv
// rtl/dvbs2_tx_pkg.sv - shared constants, pktIn bit map, FSM states and null-packet ROM for the DVB-S2 frame scheduler
package dvbs2_tx_pkg;

  localparam int TS_PKT_BYTES = 188;
  localparam int TS_PKT_BITS  = 1504;
  localparam logic [7:0] TS_SYNC = 8'h47;

  // pktIn bundle bit positions
  localparam int PKTIN_BITS        = 0;
  localparam int PKTIN_PKT_START   = 1;
  localparam int PKTIN_PKT_END     = 2;
  localparam int PKTIN_VALID       = 3;
  localparam int PKTIN_FRAME_START = 4;
  localparam int PKTIN_FRAME_END   = 5;

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} fsm_state_t;

  // Null TS packet: header 47 1F FF 10 (PID 0x1FFF), payload all 0xFF
  function automatic logic [7:0] null_byte(input logic [7:0] idx);
    case (idx)
      8'd0:    null_byte = 8'h47;
      8'd1:    null_byte = 8'h1F;
      8'd2:    null_byte = 8'hFF;
      8'd3:    null_byte = 8'h10;
      default: null_byte = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/dvbs2_tx_byte_serializer.sv
// rtl/dvbs2_tx_byte_serializer.sv - 8-bit MSB-first shifter with bit counter and load slot
//   clk, reset (sync, active-low), clear (flush)
//   load/load_data : byte written into the shifter (only while slot_open)
//   bit_valid/bit_out : current bit held at shifter[7]
//   slot_open : shifter empty or presenting its last bit, so a load keeps the stream gap-free
module dvbs2_tx_byte_serializer (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] load_data,
  output logic       bit_valid,
  output logic       bit_out,
  output logic       slot_open
);

  logic [7:0] shreg;
  logic [2:0] cnt;
  logic       full;

  assign bit_valid = full;
  assign bit_out   = shreg[7];
  assign slot_open = ~full | (cnt == 3'd7);

  // The consumer samples bit_out on the same edge that shifts it away.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      shreg <= 8'd0;
      cnt   <= 3'd0;
      full  <= 1'b0;
    end else if (load) begin
      shreg <= load_data;
      cnt   <= 3'd0;
      full  <= 1'b1;
    end else if (full) begin
      if (cnt == 3'd7) begin
        full <= 1'b0;
        cnt  <= 3'd0;
      end else begin
        shreg <= {shreg[6:0], 1'b0};
        cnt   <= cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/dvbs2_tx_frame_sched.sv
// rtl/dvbs2_tx_frame_sched.sv - DVB-S2 TX frame scheduler: TS byte stream to serial pktIn bundle
//   clk, reset (sync, active-low); tx_enable; nextFrame (sampled in IDLE only)
//   s_tdata/s_tvalid/s_tlast/s_tready : 188-byte TS packet byte stream in
//   pktIn[5:0] = {frameEnd,frameStart,pktValid,pktEnd,pktStart,pktBits}, registered
//   busy, frame_cnt (completed frames, wraps), pkt_err (sticky framing error)
//   Optional NULL_PKT_INSERT_EN: null packets fill starved packet boundaries, adds null_cnt[15:0]
module dvbs2_tx_frame_sched
  import dvbs2_tx_pkg::*;
#(
  parameter int PKTS_PER_FRAME = 4,
  parameter int FRAME_CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tx_enable,
  input  logic [7:0]             s_tdata,
  input  logic                   s_tvalid,
  input  logic                   s_tlast,
  output logic                   s_tready,
  input  logic                   nextFrame,
  output logic [5:0]             pktIn,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   pkt_err
`ifdef NULL_PKT_INSERT_EN
  ,
  output logic [15:0]            null_cnt
`endif
);

  localparam logic [0:0]  ST_IDLE     = IDLE;
  localparam logic [0:0]  ST_SEND     = SEND;
  localparam logic [11:0] FRAME_BYTES = 12'(PKTS_PER_FRAME * TS_PKT_BYTES);
  localparam logic [10:0] LAST_BIT    = 11'(TS_PKT_BITS - 1);
  localparam logic [7:0]  LAST_BYTE   = 8'(TS_PKT_BYTES - 1);
  localparam logic [3:0]  LAST_PKT    = 4'(PKTS_PER_FRAME - 1);

  logic [0:0]  state;
  logic [10:0] bit_cnt;
  logic [3:0]  pkt_idx;
  logic [7:0]  in_idx;   // byte position within packet on the input side
  logic [11:0] in_tot;   // bytes loaded into this frame

  logic       ser_valid, ser_bit, ser_slot, ser_load;
  logic [7:0] ser_data;
  logic       sending, can_load, emit, real_load;
  logic       pkt_first, pkt_last, frame_last, start_frame;

  assign sending     = (state == ST_SEND);
  assign can_load    = sending & ser_slot & (in_tot < FRAME_BYTES);
  assign emit        = sending & ser_valid;
  assign pkt_first   = (bit_cnt == 11'd0);
  assign pkt_last    = (bit_cnt == LAST_BIT);
  assign frame_last  = pkt_last & (pkt_idx == LAST_PKT);
  assign start_frame = ~sending & tx_enable & nextFrame;

`ifdef NULL_PKT_INSERT_EN
  logic null_active, null_start, null_load;

  // A packet boundary with no upstream byte ready starts a null packet
  // in the same slot, so the frame never stalls between packets.
  always_comb begin
    null_start = can_load & ~null_active & (in_idx == 8'd0) & ~s_tvalid;
    null_load  = null_start | (null_active & can_load);
    s_tready   = can_load & ~null_active;
    real_load  = s_tready & s_tvalid;
    ser_load   = real_load | null_load;
    ser_data   = null_load ? null_byte(in_idx) : s_tdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      null_active <= 1'b0;
      null_cnt    <= 16'd0;
    end else begin
      if (!sending)
        null_active <= 1'b0;
      else if (null_start)
        null_active <= 1'b1;
      else if (null_load && in_idx == LAST_BYTE)
        null_active <= 1'b0;
      if (null_start)
        null_cnt <= null_cnt + 16'd1;
    end
  end
`else
  always_comb begin
    s_tready  = can_load;
    real_load = can_load & s_tvalid;
    ser_load  = real_load;
    ser_data  = s_tdata;
  end
`endif

  dvbs2_tx_byte_serializer u_ser (
    .clk       (clk),
    .reset     (reset),
    .clear     (~sending),
    .load      (ser_load),
    .load_data (ser_data),
    .bit_valid (ser_valid),
    .bit_out   (ser_bit),
    .slot_open (ser_slot)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      pktIn     <= 6'd0;
      busy      <= 1'b0;
      frame_cnt <= '0;
      pkt_err   <= 1'b0;
      bit_cnt   <= 11'd0;
      pkt_idx   <= 4'd0;
      in_idx    <= 8'd0;
      in_tot    <= 12'd0;
    end else begin
      pktIn <= 6'd0;
      if (emit) begin
        pktIn[PKTIN_BITS]        <= ser_bit;
        pktIn[PKTIN_PKT_START]   <= pkt_first;
        pktIn[PKTIN_PKT_END]     <= pkt_last;
        pktIn[PKTIN_VALID]       <= 1'b1;
        pktIn[PKTIN_FRAME_START] <= pkt_first & (pkt_idx == 4'd0);
        pktIn[PKTIN_FRAME_END]   <= frame_last;
      end

      // busy stays high through the cycle that shows frameEnd
      busy <= sending | start_frame;

      if (start_frame)
        state <= ST_SEND;
      else if (emit && frame_last)
        state <= ST_IDLE;

      if (emit && frame_last)
        frame_cnt <= frame_cnt + 1'b1;

      if (!sending) begin
        bit_cnt <= 11'd0;
        pkt_idx <= 4'd0;
        in_idx  <= 8'd0;
        in_tot  <= 12'd0;
      end else begin
        if (emit) begin
          bit_cnt <= pkt_last ? 11'd0 : bit_cnt + 11'd1;
          if (pkt_last)
            pkt_idx <= frame_last ? 4'd0 : pkt_idx + 4'd1;
        end
        if (ser_load) begin
          in_idx <= (in_idx == LAST_BYTE) ? 8'd0 : in_idx + 8'd1;
          in_tot <= in_tot + 12'd1;
        end
      end

      if (real_load && (((in_idx == 8'd0) && (s_tdata != TS_SYNC)) ||
                        (s_tlast != (in_idx == LAST_BYTE))))
        pkt_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dvbs2_tx_frame_sched.sv
// tb/tb_dvbs2_tx_frame_sched.sv - directed self-checking bench for dvbs2_tx_frame_sched
module tb_dvbs2_tx_frame_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, tx_enable, s_tvalid, s_tlast, s_tready, nextFrame, busy, pkt_err;
  logic [7:0]  s_tdata;
  logic [5:0]  pktIn;
  logic [15:0] frame_cnt;
`ifdef NULL_PKT_INSERT_EN
  logic [15:0] null_cnt;
`endif

  dvbs2_tx_frame_sched #(.PKTS_PER_FRAME(4), .FRAME_CNT_W(16)) dut (
    .clk(clk), .reset(reset), .tx_enable(tx_enable),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .nextFrame(nextFrame), .pktIn(pktIn), .busy(busy), .frame_cnt(frame_cnt), .pkt_err(pkt_err)
`ifdef NULL_PKT_INSERT_EN
    , .null_cnt(null_cnt)
`endif
  );

  int vectors = 0;
  int errors  = 0;

  int cyc = 0, vcount, first_v, fe_cyc, fs_n, fe_n, ps_n, gaps, bit_errs, pos_errs, junk, busy_cyc, obit;
  bit chk_bits = 1'b1;
  logic [31:0] cap32;
  int src_ptr = 0, hold_left = 0, blk_ptr = -1, blk_left = 0, bad0_ptr = -1, tlast_ptr = -1;
  bit src_on = 1'b0, hold_req = 1'b0;

  function automatic logic [7:0] src_byte(input int p);
    int k, i;
    k = p / 188;
    i = p % 188;
    if (p == bad0_ptr) return 8'h48;
    if (i == 0) return 8'h47;
    return 8'((k * 29 + i * 7 + 3) % 256);
  endfunction

  function automatic logic src_last(input int p);
    return ((p % 188) == 187) || (p == tlast_ptr);
  endfunction

  task automatic mon_clear();
    vcount = 0; first_v = -1; fe_cyc = -1; fs_n = 0; fe_n = 0; ps_n = 0;
    gaps = 0; bit_errs = 0; pos_errs = 0; junk = 0; busy_cyc = -1;
    obit = src_ptr * 8; cap32 = 32'd0;
  endtask

  // One clock: observe outputs at negedge, then drive inputs for the next posedge.
  task automatic tick();
    logic [7:0] eb;
    @(negedge clk);
    cyc++;
    if (pktIn[3]) begin
      eb = src_byte(obit / 8);
      if (vcount == 0) first_v = cyc;
      if (chk_bits && pktIn[0] !== eb[7 - (obit % 8)]) bit_errs++;
      if (pktIn[1] !== ((vcount % 1504) == 0))    pos_errs++;
      if (pktIn[2] !== ((vcount % 1504) == 1503)) pos_errs++;
      if (pktIn[4] !== (vcount == 0))             pos_errs++;
      if (pktIn[5] !== (vcount == 6015))          pos_errs++;
      if (pktIn[1]) ps_n++;
      if (pktIn[4]) fs_n++;
      if (pktIn[5]) begin fe_n++; fe_cyc = cyc; end
      if (vcount >= 3008 && vcount < 3040) cap32 = {cap32[30:0], pktIn[0]};
      obit++;
      vcount++;
    end else begin
      if (pktIn !== 6'd0) junk++;
      if (vcount > 0 && fe_n == 0) gaps++;
    end
    if (busy === 1'b1 && busy_cyc < 0) busy_cyc = cyc;
    if (hold_req && s_tready && vcount >= 200) begin hold_left = 5; hold_req = 1'b0; end
    s_tdata  = src_byte(src_ptr);
    s_tlast  = src_last(src_ptr);
    s_tvalid = src_on && hold_left == 0 && !(src_ptr == blk_ptr && blk_left > 0);
    if (src_ptr == blk_ptr && blk_left > 0) blk_left--;
    if (hold_left > 0) hold_left--;
    if (s_tvalid && s_tready) src_ptr++;
  endtask

  task automatic run_frame(input int budget);
    int n;
    n = 0;
    while (fe_n == 0 && n < budget) begin
      tick();
      if (busy) tx_enable = 1'b0;
      n++;
    end
    vectors++;
    if (fe_n == 0) begin errors++; $display("FAIL frame_timeout: no frameEnd within %0d cycles", budget); end
    tick();
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_frameEnd: got %b want 0", busy); end
  endtask

  task automatic test_reset();
    reset = 1'b0; tx_enable = 1'b1; nextFrame = 1'b1; src_on = 1'b1;
    tick(); tick();
    vectors++; if (pktIn !== 6'd0)      begin errors++; $display("FAIL reset_pktIn: got %h want 00", pktIn); end
    vectors++; if (s_tready !== 1'b0)   begin errors++; $display("FAIL reset_tready: got %b want 0", s_tready); end
    vectors++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
    vectors++; if (pkt_err !== 1'b0)    begin errors++; $display("FAIL reset_pkt_err: got %b want 0", pkt_err); end
    tx_enable = 1'b0; nextFrame = 1'b0;
    reset = 1'b1;
    tick(); tick();
    vectors++; if (busy !== 1'b0 || s_tready !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy %b tready %b want 0 0", busy, s_tready); end
  endtask

  task automatic test_full_frame();
    mon_clear();
    tx_enable = 1'b1; nextFrame = 1'b1; src_on = 1'b1;
    run_frame(6500);
    nextFrame = 1'b0;
    vectors++; if (vcount != 6016)   begin errors++; $display("FAIL t1_valid_bits: got %0d want 6016", vcount); end
    vectors++; if (gaps != 0)        begin errors++; $display("FAIL t1_gaps: got %0d want 0", gaps); end
    vectors++; if (ps_n != 4)        begin errors++; $display("FAIL t1_pktStart_count: got %0d want 4", ps_n); end
    vectors++; if (fe_cyc != first_v + 6015) begin errors++; $display("FAIL t1_frameEnd_pos: got %0d want %0d", fe_cyc - first_v + 1, 6016); end
    vectors++; if (pos_errs != 0 || junk != 0) begin errors++; $display("FAIL t1_flags: got pos %0d junk %0d want 0 0", pos_errs, junk); end
    vectors++; if (bit_errs != 0)    begin errors++; $display("FAIL t1_bits: got %0d bad bits want 0", bit_errs); end
    vectors++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL t1_frame_cnt: got %0d want 1", frame_cnt); end
  endtask

  task automatic test_next_frame_gate();
    int bad, raise_cyc;
    mon_clear();
    bad = 0;
    tx_enable = 1'b1; nextFrame = 1'b0; src_on = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_tready !== 1'b0 || pktIn !== 6'd0 || busy !== 1'b0) bad++;
    end
    vectors++; if (bad != 0) begin errors++; $display("FAIL t2_idle_hold: got %0d active cycles want 0", bad); end
    nextFrame = 1'b1;
    raise_cyc = cyc;
    run_frame(6500);
    nextFrame = 1'b0;
    vectors++; if (busy_cyc != raise_cyc + 1) begin errors++; $display("FAIL t2_busy_rise: got +%0d want +1", busy_cyc - raise_cyc); end
    vectors++; if (first_v != raise_cyc + 3)  begin errors++; $display("FAIL t2_first_bit: got +%0d want +3", first_v - raise_cyc); end
    vectors++; if (bit_errs != 0 || vcount != 6016) begin errors++; $display("FAIL t2_frame: got %0d bad %0d bits want 0 6016", bit_errs, vcount); end
    vectors++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL t2_frame_cnt: got %0d want 2", frame_cnt); end
  endtask

  task automatic test_mid_gap();
    mon_clear();
    hold_req = 1'b1;
    tx_enable = 1'b1; nextFrame = 1'b1; src_on = 1'b1;
    run_frame(6500);
    nextFrame = 1'b0;
    vectors++; if (gaps != 5)        begin errors++; $display("FAIL t3_gaps: got %0d want 5", gaps); end
    vectors++; if (vcount != 6016 || pos_errs != 0) begin errors++; $display("FAIL t3_frame: got %0d bits %0d pos want 6016 0", vcount, pos_errs); end
    vectors++; if (bit_errs != 0)    begin errors++; $display("FAIL t3_bits: got %0d bad bits want 0", bit_errs); end
    vectors++; if (pkt_err !== 1'b0) begin errors++; $display("FAIL t3_pkt_err_clean: got %b want 0", pkt_err); end
  endtask

  task automatic test_pkt_err();
    mon_clear();
    bad0_ptr = src_ptr; tlast_ptr = src_ptr + 100;
    tx_enable = 1'b1; nextFrame = 1'b1; src_on = 1'b1;
    run_frame(6500);
    nextFrame = 1'b0;
    vectors++; if (pkt_err !== 1'b1) begin errors++; $display("FAIL t4_pkt_err: got %b want 1", pkt_err); end
    vectors++; if (bit_errs != 0 || vcount != 6016) begin errors++; $display("FAIL t4_forward: got %0d bad %0d bits want 0 6016", bit_errs, vcount); end
    bad0_ptr = -1; tlast_ptr = -1;
    for (int i = 0; i < 20; i++) tick();
    vectors++; if (pkt_err !== 1'b1) begin errors++; $display("FAIL t4_pkt_err_sticky: got %b want 1", pkt_err); end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    mon_clear();
    tx_enable = 1'b1; nextFrame = 1'b1; src_on = 1'b1;
    n = 0;
    while (vcount < 700 && n < 1000) begin tick(); if (busy) tx_enable = 1'b0; n++; end
    vectors++; if (vcount != 700) begin errors++; $display("FAIL t5_reach_bit700: got %0d want 700", vcount); end
    reset = 1'b0;
    tick();
    vectors++; if (pktIn !== 6'd0)      begin errors++; $display("FAIL t5_pktIn: got %h want 00", pktIn); end
    vectors++; if (busy !== 1'b0)       begin errors++; $display("FAIL t5_busy: got %b want 0", busy); end
    vectors++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL t5_frame_cnt: got %0d want 0", frame_cnt); end
    vectors++; if (fe_n != 0 || pkt_err !== 1'b0) begin errors++; $display("FAIL t5_abandon: got fe %0d err %b want 0 0", fe_n, pkt_err); end
    reset = 1'b1;
    src_ptr = ((src_ptr + 187) / 188) * 188;
    mon_clear();
    tx_enable = 1'b1; nextFrame = 1'b1;
    run_frame(6500);
    nextFrame = 1'b0;
    vectors++; if (fs_n != 1 || pos_errs != 0) begin errors++; $display("FAIL t5_restart_flags: got fs %0d pos %0d want 1 0", fs_n, pos_errs); end
    vectors++; if (bit_errs != 0 || vcount != 6016) begin errors++; $display("FAIL t5_restart_frame: got %0d bad %0d bits want 0 6016", bit_errs, vcount); end
    vectors++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL t5_frame_cnt_after: got %0d want 1", frame_cnt); end
  endtask

`ifdef NULL_PKT_INSERT_EN
  task automatic test_null_insert();
    mon_clear();
    chk_bits = 1'b0;
    blk_ptr = src_ptr + 376; blk_left = 10;
    tx_enable = 1'b1; nextFrame = 1'b1; src_on = 1'b1;
    run_frame(6500);
    nextFrame = 1'b0; chk_bits = 1'b1; blk_ptr = -1;
    vectors++; if (vcount != 6016 || gaps != 0) begin errors++; $display("FAIL t6_contiguous: got %0d bits %0d gaps want 6016 0", vcount, gaps); end
    vectors++; if (cap32 !== 32'h471FFF10) begin errors++; $display("FAIL t6_null_header: got %h want 471fff10", cap32); end
    vectors++; if (null_cnt !== 16'd1) begin errors++; $display("FAIL t6_null_cnt: got %0d want 1", null_cnt); end
    vectors++; if (pos_errs != 0) begin errors++; $display("FAIL t6_flags: got %0d want 0", pos_errs); end
  endtask
`endif

  initial begin
    reset = 1'b0; tx_enable = 1'b0; nextFrame = 1'b0;
    s_tdata = 8'd0; s_tvalid = 1'b0; s_tlast = 1'b0;
    test_reset();
    test_full_frame();
    test_next_frame_gate();
    test_mid_gap();
    test_pkt_err();
    test_reset_mid_frame();
`ifdef NULL_PKT_INSERT_EN
    test_null_insert();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
